// File: rtl/core_inst_sequencer.sv
// Weight-stationary tile sequencer driving the 34-bit core instruction word.
// Optional SEQ_PERF_CNT_EN adds busy, l0-stall and drain-wait counters.
module core_inst_sequencer #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int aw       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] w_base,
  input  logic [aw-1:0] a_base,
  input  logic [aw-1:0] p_base,
  input  logic [4:0]    l0_ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_l0_stall,
  output logic [31:0]   perf_drain_wait
`endif
);

  localparam logic [33:0] INST_RST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    IDLE, W2L0, WLOAD, WSETTLE, A2L0, EXEC, DRAIN, DONE
  } state_t;

  state_t        state_q;
  logic [33:0]   inst_q;
  logic          busy_q;
  logic          done_q;
  logic          rd_q;
  logic [7:0]    k_q;
  logic [15:0]   i_q;
  logic [15:0]   j_q;
  logic [aw-1:0] w_q;
  logic [aw-1:0] a_q;
  logic [aw-1:0] p_q;

  logic [15:0]   nrd;
  logic [aw-1:0] xaddr;
  logic          l0_full;
  logic          of_valid;
  logic          unused_status;

  assign l0_full       = l0_ofifo_valid[1];
  assign of_valid      = l0_ofifo_valid[4];
  assign unused_status = ^{l0_ofifo_valid[3:2], l0_ofifo_valid[0]};

  always_comb begin
    nrd   = 16'(col);
    xaddr = w_q + aw'(k_q * col) + aw'(i_q);
    if (state_q == A2L0) begin
      nrd   = 16'(len_onij);
      xaddr = a_q + aw'(k_q * len_onij) + aw'(i_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      inst_q  <= INST_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      w_q     <= '0;
      a_q     <= '0;
      p_q     <= '0;
    end else begin
      inst_q <= INST_RST;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            w_q     <= w_base;
            a_q     <= a_base;
            p_q     <= p_base;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= W2L0;
          end
        end
        W2L0, A2L0: begin
          // l0_wr trails each read by one cycle (SRAM read latency)
          inst_q[2] <= rd_q;
          if (i_q == nrd) begin
            i_q     <= '0;
            state_q <= (state_q == W2L0) ? WLOAD : EXEC;
          end else begin
            inst_q[17:7] <= xaddr;
            if (!l0_full) begin
              inst_q[19] <= 1'b0;
              rd_q       <= 1'b1;
              i_q        <= i_q + 16'd1;
            end
          end
        end
        WLOAD: begin
          inst_q[0] <= 1'b1;
          inst_q[3] <= 1'b1;
          if (i_q == 16'(col - 1)) begin
            i_q     <= '0;
            state_q <= WSETTLE;
          end else begin
            i_q <= i_q + 16'd1;
          end
        end
        WSETTLE: begin
          if (i_q == 16'(row + col - 1)) begin
            i_q     <= '0;
            state_q <= A2L0;
          end else begin
            i_q <= i_q + 16'd1;
          end
        end
        EXEC: begin
          inst_q[1] <= 1'b1;
          inst_q[3] <= 1'b1;
          if (i_q == 16'(len_onij - 1)) begin
            i_q     <= '0;
            j_q     <= '0;
            state_q <= DRAIN;
          end else begin
            i_q <= i_q + 16'd1;
          end
        end
        DRAIN: begin
          if (of_valid) begin
            inst_q[6]     <= 1'b1;
            inst_q[32]    <= 1'b0;
            inst_q[31]    <= 1'b0;
            inst_q[30:20] <= p_q + aw'(j_q);
            inst_q[33]    <= (k_q != 8'd0);
            if (j_q == 16'(len_onij - 1)) begin
              j_q <= '0;
              if (k_q == 8'(len_kij - 1)) begin
                state_q <= DONE;
              end else begin
                k_q     <= k_q + 8'd1;
                state_q <= W2L0;
              end
            end else begin
              j_q <= j_q + 16'd1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] pc_q;
  logic [31:0] ps_q;
  logic [31:0] pd_q;
  logic        rd_phase;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rd_phase = (state_q == W2L0 || state_q == A2L0) && (i_q != nrd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ps_q <= '0;
      pd_q <= '0;
    end else if (state_q == IDLE && start) begin
      pc_q <= '0;
      ps_q <= '0;
      pd_q <= '0;
    end else begin
      if (busy_q)
        pc_q <= sat_inc(pc_q);
      if (rd_phase && l0_full)
        ps_q <= sat_inc(ps_q);
      if (state_q == DRAIN && !of_valid)
        pd_q <= sat_inc(pd_q);
    end
  end

  assign perf_cycles     = pc_q;
  assign perf_l0_stall   = ps_q;
  assign perf_drain_wait = pd_q;
`endif

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer: directed scenarios plus
// randomized tiles checked against an event-level reference model.
module tb_core_inst_sequencer;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int KIJ  = 9;
  localparam int ONIJ = 16;
  localparam int AW   = 11;
  localparam int LIM  = 4000;
  localparam logic [33:0] RST = 34'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] w_base;
  logic [AW-1:0] a_base;
  logic [AW-1:0] p_base;
  logic [4:0]    l0_ofifo_valid;
  logic [33:0]   inst;
  logic          busy;
  logic          done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_l0_stall;
  logic [31:0]   perf_drain_wait;
`endif

  int passed = 0;
  int total  = 0;
  int cyc_g, rd_cnt, lwr_cnt;

  always #5 clk = ~clk;

  core_inst_sequencer #(
    .row(ROW), .col(COL), .len_kij(KIJ), .len_onij(ONIJ), .aw(AW)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .w_base(w_base),
    .a_base(a_base),
    .p_base(p_base),
    .l0_ofifo_valid(l0_ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_l0_stall(perf_l0_stall),
    .perf_drain_wait(perf_drain_wait)
`endif
  );

  task automatic tick();
    @(negedge clk);
    cyc_g++;
    if (inst[19] === 1'b0) rd_cnt++;
    if (inst[2] === 1'b1) lwr_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    w_base = '0;
    a_base = '0;
    p_base = '0;
    l0_ofifo_valid = 5'b10000;
    repeat (2) @(negedge clk);
    total++;
    if (inst !== RST) $display("FAIL reset inst: got %h want %h", inst, RST);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
    else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (inst !== RST || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle after reset: got inst=%h busy=%b done=%b want %h 0 0",
               inst, busy, done, RST);
    else passed++;
  endtask

  task automatic test_stall_abort();
    int bad;
    w_base = '0;
    a_base = 11'h100;
    p_base = '0;
    l0_ofifo_valid = 5'b10000;
    cyc_g = 0;
    rd_cnt = 0;
    lwr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL busy after start: got %b want 1", busy);
    else passed++;
    while (inst[19] !== 1'b0 && cyc_g < LIM) tick();
    total++;
    if (inst[19] !== 1'b0 || inst[17:7] !== 11'd0)
      $display("FAIL first read: got cen=%b a=%h want 0 000", inst[19], inst[17:7]);
    else passed++;
    total++;
    if (inst[2] !== 1'b0) $display("FAIL l0_wr with first read: got %b want 0", inst[2]);
    else passed++;
    tick();
    total++;
    if (inst[2] !== 1'b1) $display("FAIL first l0_wr: got %b want 1", inst[2]);
    else passed++;
    while (rd_cnt < 4 && cyc_g < LIM) tick();
    l0_ofifo_valid[1] = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (inst[19] !== 1'b1 || inst[17:7] !== 11'd4) bad++;
    end
    l0_ofifo_valid[1] = 1'b0;
    total++;
    if (bad != 0) $display("FAIL stall hold: got %0d bad cycles want 0", bad);
    else passed++;
    tick();
    total++;
    if (inst[19] !== 1'b0 || inst[17:7] !== 11'd4)
      $display("FAIL read after stall: got cen=%b a=%h want 0 004", inst[19], inst[17:7]);
    else passed++;
    while (inst[0] !== 1'b1 && cyc_g < LIM) tick();
    total++;
    if (rd_cnt != COL || lwr_cnt != COL)
      $display("FAIL stall counts: got rd=%0d l0_wr=%0d want %0d %0d",
               rd_cnt, lwr_cnt, COL, COL);
    else passed++;
    while (inst[1] !== 1'b1 && cyc_g < LIM) tick();
    start = 1'b1;
    w_base = 11'h055;
    a_base = 11'h333;
    p_base = 11'h222;
    tick();
    start = 1'b0;
    while (inst[32] !== 1'b0 && cyc_g < LIM) tick();
    total++;
    if (inst[32] !== 1'b0 || inst[30:20] !== 11'd0 || inst[33] !== 1'b0)
      $display("FAIL first write after busy start: got cen=%b a=%h acc=%b want 0 000 0",
               inst[32], inst[30:20], inst[33]);
    else passed++;
    while (inst[19] !== 1'b0 && cyc_g < LIM) tick();
    total++;
    if (inst[17:7] !== 11'd8)
      $display("FAIL k1 weight read: got %h want 008", inst[17:7]);
    else passed++;
    while (inst[0] !== 1'b1 && cyc_g < LIM) tick();
    while (inst[19] !== 1'b0 && cyc_g < LIM) tick();
    total++;
    if (inst[17:7] !== 11'h110)
      $display("FAIL k1 act read: got %h want 110", inst[17:7]);
    else passed++;
    while (inst[1] !== 1'b1 && cyc_g < LIM) tick();
    total++;
    if (cyc_g >= LIM) $display("FAIL directed timeout: got %0d cycles want <%0d", cyc_g, LIM);
    else passed++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (inst !== RST || busy !== 1'b0)
      $display("FAIL async abort: got inst=%h busy=%b want %h 0", inst, busy, RST);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || inst !== RST)
      $display("FAIL idle after abort: got busy=%b inst=%h want 0 %h", busy, inst, RST);
    else passed++;
  endtask

  task automatic run_tile(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb, input int l0_pct,
                          input int of_pct, input int hold_of,
                          input string nm, output int bcyc);
    logic [33:0]   tr[$];
    bit            l0s[$];
    bit            ofs[$];
    logic [AW-1:0] erd[$];
    logic [AW-1:0] grd[$];
    logic [33:0]   w;
    logic [AW-1:0] ea;
    int nwr, nlwr, nld, nex, cyc, held, last_ld, gap;
    int b_addr, b_pair, b_rd, b_wr, b_const, b_stall, b_gap;
    bit first_wr, ld_pend;
    w_base = wb;
    a_base = ab;
    p_base = pb;
    l0_ofifo_valid = 5'b10000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL %s busy after start: got %b want 1", nm, busy);
    else passed++;
    cyc = 0;
    held = 0;
    bcyc = 0;
    first_wr = 1'b0;
    while (done !== 1'b1 && cyc < 20000) begin
      tr.push_back(inst);
      if (busy === 1'b1) bcyc++;
      if (inst[32] === 1'b0 && !first_wr) begin
        first_wr = 1'b1;
        held = hold_of;
      end
      l0_ofifo_valid[1] = (int'($urandom_range(99)) < l0_pct);
      if (held > 0) begin
        l0_ofifo_valid[4] = 1'b0;
        held--;
      end else begin
        l0_ofifo_valid[4] = (int'($urandom_range(99)) >= of_pct);
      end
      l0s.push_back(l0_ofifo_valid[1]);
      ofs.push_back(l0_ofifo_valid[4]);
      @(negedge clk);
      cyc++;
    end
    l0_ofifo_valid = 5'b10000;
    total++;
    if (done !== 1'b1) $display("FAIL %s done: got %b want 1 within 20000 cycles", nm, done);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL %s busy at done: got %b want 0", nm, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL %s done pulse: got %b want 0", nm, done);
    else passed++;

    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < COL; i++) erd.push_back(wb + AW'(k * COL + i));
      for (int i = 0; i < ONIJ; i++) erd.push_back(ab + AW'(k * ONIJ + i));
    end
    nwr = 0; nlwr = 0; nld = 0; nex = 0; last_ld = 0; ld_pend = 1'b0;
    b_addr = 0; b_pair = 0; b_rd = 0; b_wr = 0; b_const = 0; b_stall = 0; b_gap = 0;
    for (int t = 0; t < tr.size(); t++) begin
      w = tr[t];
      if (w[18] !== 1'b1 || w[5] !== 1'b0 || w[4] !== 1'b0) b_const++;
      if (w[19] === 1'b0) begin
        grd.push_back(w[17:7]);
        if (t + 1 >= tr.size() || tr[t+1][2] !== 1'b1) b_pair++;
        if (ld_pend) begin
          gap = t - last_ld;
          if (l0_pct == 0 ? gap != ROW + COL + 1 : gap < ROW + COL + 1) b_gap++;
          ld_pend = 1'b0;
        end
      end
      if (w[2] === 1'b1) nlwr++;
      if (w[0] === 1'b1) begin
        nld++;
        last_ld = t;
        ld_pend = 1'b1;
        if (w[3] !== 1'b1) b_rd++;
      end
      if (w[1] === 1'b1) begin
        nex++;
        if (w[3] !== 1'b1) b_rd++;
      end
      if (w[32] === 1'b0) begin
        ea = pb + AW'(nwr % ONIJ);
        if (w[31] !== 1'b0 || w[6] !== 1'b1 || w[30:20] !== ea ||
            w[33] !== (nwr >= ONIJ)) b_wr++;
        nwr++;
      end else if (w[33] !== 1'b0 || w[6] !== 1'b0) begin
        b_wr++;
      end
      if (t > 0 && l0s[t-1] && w[19] !== 1'b1) b_stall++;
      if (t > 0 && !ofs[t-1] && w[32] !== 1'b1) b_stall++;
    end
    for (int n = 0; n < erd.size() && n < grd.size(); n++)
      if (grd[n] !== erd[n]) b_addr++;
    total++;
    if (grd.size() != erd.size())
      $display("FAIL %s read count: got %0d want %0d", nm, grd.size(), erd.size());
    else passed++;
    total++;
    if (b_addr != 0) $display("FAIL %s read addr: got %0d bad want 0", nm, b_addr);
    else passed++;
    total++;
    if (b_pair != 0) $display("FAIL %s l0_wr pairing: got %0d bad want 0", nm, b_pair);
    else passed++;
    total++;
    if (nlwr != erd.size())
      $display("FAIL %s l0_wr count: got %0d want %0d", nm, nlwr, erd.size());
    else passed++;
    total++;
    if (nld != KIJ * COL) $display("FAIL %s load count: got %0d want %0d", nm, nld, KIJ * COL);
    else passed++;
    total++;
    if (nex != KIJ * ONIJ)
      $display("FAIL %s exec count: got %0d want %0d", nm, nex, KIJ * ONIJ);
    else passed++;
    total++;
    if (b_rd != 0) $display("FAIL %s l0_rd: got %0d bad want 0", nm, b_rd);
    else passed++;
    total++;
    if (nwr != KIJ * ONIJ)
      $display("FAIL %s pmem writes: got %0d want %0d", nm, nwr, KIJ * ONIJ);
    else passed++;
    total++;
    if (b_wr != 0) $display("FAIL %s pmem addr/acc: got %0d bad want 0", nm, b_wr);
    else passed++;
    total++;
    if (b_const != 0) $display("FAIL %s fixed fields: got %0d bad want 0", nm, b_const);
    else passed++;
    total++;
    if (b_stall != 0) $display("FAIL %s stall response: got %0d bad want 0", nm, b_stall);
    else passed++;
    total++;
    if (b_gap != 0) $display("FAIL %s settle gap: got %0d bad want 0", nm, b_gap);
    else passed++;
  endtask

  task automatic test_full_tile();
    int bc;
    run_tile(11'h000, 11'h100, 11'h000, 0, 0, 0, "full", bc);
  endtask

  task automatic test_wrap();
    int bc;
    run_tile(11'h7FC, 11'h7FF, 11'h7F8, 0, 0, 0, "wrap", bc);
  endtask

  task automatic test_random();
    int bc;
    for (int n = 0; n < 3; n++)
      run_tile(AW'($urandom), AW'($urandom), AW'($urandom), 30, 30, 0, "random", bc);
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf();
    int bc;
    run_tile(11'h010, 11'h200, 11'h040, 0, 0, 5, "perf", bc);
    total++;
    if (perf_drain_wait !== 32'd5)
      $display("FAIL perf_drain_wait: got %0d want 5", perf_drain_wait);
    else passed++;
    total++;
    if (perf_cycles !== 32'(bc))
      $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, bc);
    else passed++;
    total++;
    if (perf_l0_stall !== 32'd0)
      $display("FAIL perf_l0_stall: got %0d want 0", perf_l0_stall);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_stall_abort();
    test_full_tile();
    test_wrap();
    test_random();
`ifdef SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
